// File: rtl/mu0_seq_pkg.sv
// Shared constants for the MU0 phase sequencer: state codes, opcodes,
// extension-select codes and the default extension watchdog limit.
package mu0_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_HALT     = 3'd0;
  localparam state_t ST_FETCH    = 3'd1;
  localparam state_t ST_EXEC1    = 3'd2;
  localparam state_t ST_EXEC2    = 3'd3;
  localparam state_t ST_EXT_WAIT = 3'd4;

  localparam logic [3:0] OP_STP = 4'b0111;

  localparam logic [1:0] EXT_SEL_NONE = 2'b00;
  localparam logic [1:0] EXT_SEL_FBC  = 2'b01;
  localparam logic [1:0] EXT_SEL_RND  = 2'b10;
  localparam logic [1:0] EXT_SEL_LNK  = 2'b11;

  localparam int EXT_TIMEOUT_DEF = 200;

  // FBC wins over RND, RND over LNK
  function automatic logic [1:0] ext_pick(
    input logic fbc,
    input logic rnd,
    input logic lnk
  );
    logic [1:0] sel;
    sel = EXT_SEL_NONE;
    if (fbc)      sel = EXT_SEL_FBC;
    else if (rnd) sel = EXT_SEL_RND;
    else if (lnk) sel = EXT_SEL_LNK;
    return sel;
  endfunction

endpackage

// File: rtl/mu0_ext_watchdog.sv
// Extension watchdog: counts cycles while enabled and flags expiry
// when the count reaches EXT_TIMEOUT-1.
import mu0_seq_pkg::*;

module mu0_ext_watchdog #(
  parameter int TMO_W       = 8,
  parameter int EXT_TIMEOUT = EXT_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMO_W-1:0] LIMIT = TMO_W'(EXT_TIMEOUT - 1);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (enable)    cnt <= cnt + 1'b1;
  end

  assign expired = enable && (cnt == LIMIT);

endmodule

// File: rtl/mu0_phase_sequencer.sv
// MU0 Fetch/Exec1/Exec2 phase controller with extension handshake.
// Define MU0_SINGLE_STEP_EN to gate FETCH->EXEC1 on the step input.
import mu0_seq_pkg::*;

module mu0_phase_sequencer #(
  parameter int CNT_W       = 16,
  parameter int TMO_W       = 8,
  parameter int EXT_TIMEOUT = EXT_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [3:0]       op,
  input  logic             extra,
  input  logic             fbc_check,
  input  logic             rnd_check,
  input  logic             lnk_check,
  input  logic             ext_done,
  input  logic             step,
  output logic             fetch,
  output logic             exec1,
  output logic             exec2,
  output logic             ext_req,
  output logic [1:0]       ext_sel,
  output logic             halted,
  output logic             timeout_err,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t state;
  state_t nxt;
  logic   expired;
  logic   any_check;
  logic   retire;

  assign any_check = fbc_check | rnd_check | lnk_check;

`ifndef MU0_SINGLE_STEP_EN
  logic unused_step;
  assign unused_step = step;
`endif

  mu0_ext_watchdog #(
    .TMO_W       (TMO_W),
    .EXT_TIMEOUT (EXT_TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != ST_EXT_WAIT),
    .enable  (state == ST_EXT_WAIT),
    .expired (expired)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      ST_HALT: begin
        if (go) nxt = ST_FETCH;
      end
      ST_FETCH: begin
`ifdef MU0_SINGLE_STEP_EN
        if (step) nxt = ST_EXEC1;
`else
        nxt = ST_EXEC1;
`endif
      end
      ST_EXEC1: begin
        if (op == OP_STP)   nxt = ST_HALT;
        else if (any_check) nxt = ST_EXT_WAIT;
        else if (extra)     nxt = ST_EXEC2;
        else                nxt = ST_FETCH;
      end
      ST_EXEC2: nxt = ST_FETCH;
      ST_EXT_WAIT: begin
        // a done arriving on the expiry cycle still completes normally
        if (ext_done)     nxt = ST_FETCH;
        else if (expired) nxt = ST_HALT;
      end
      default: nxt = ST_HALT;
    endcase
  end

  assign retire = (nxt == ST_FETCH) &&
                  ((state == ST_EXEC1) ||
                   (state == ST_EXEC2) ||
                   (state == ST_EXT_WAIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_HALT;
      ext_sel     <= EXT_SEL_NONE;
      timeout_err <= 1'b0;
      instr_cnt   <= '0;
    end else begin
      state <= nxt;
      if (state == ST_EXEC1 && nxt == ST_EXT_WAIT)
        ext_sel <= ext_pick(fbc_check, rnd_check, lnk_check);
      else if (nxt != ST_EXT_WAIT)
        ext_sel <= EXT_SEL_NONE;
      if (state == ST_HALT && go)
        timeout_err <= 1'b0;
      else if (state == ST_EXT_WAIT && nxt == ST_HALT)
        timeout_err <= 1'b1;
      if (retire && (instr_cnt != '1))
        instr_cnt <= instr_cnt + 1'b1;
    end
  end

  assign fetch   = (state == ST_FETCH);
  assign exec1   = (state == ST_EXEC1);
  assign exec2   = (state == ST_EXEC2);
  assign ext_req = (state == ST_EXT_WAIT);
  assign halted  = (state == ST_HALT);

endmodule
